// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues held-until-acked IMEM requests and feeds the IF/ID register.
// Optional FETCH_PERF_EN adds saturating fetched/stall counters.
module fetch_stage #(
  parameter int                   ADDR_W    = 32,
  parameter int                   INSTR_W   = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC  = 32'h0000_0000,
  parameter int                   PC_INC    = 4,
  parameter logic [INSTR_W-1:0]   NOP_INSTR = 32'h0000_0013
) (
  input  logic               CLK,
  input  logic               RST,
  output logic               IMEM_REQ,
  output logic [ADDR_W-1:0]  IMEM_ADDR,
  input  logic               IMEM_ACK,
  input  logic [INSTR_W-1:0] IMEM_RDATA,
  input  logic               REDIRECT,
  input  logic [ADDR_W-1:0]  REDIRECT_PC,
  input  logic               ID_READY,
  output logic               IF_ID_VALID,
  output logic [ADDR_W-1:0]  IF_ID_PC,
  output logic [INSTR_W-1:0] IF_ID_INSTR
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        PERF_FETCHED,
  output logic [31:0]        PERF_STALL
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_FULL} state_t;

  state_t               state, state_n;
  logic [ADDR_W-1:0]    pc_p0, pc_n;
  logic [ADDR_W-1:0]    req_addr_p0, req_addr_n;
  logic                 drop, drop_n;
  logic [ADDR_W-1:0]    skid_pc_p1, skid_pc_n;
  logic [INSTR_W-1:0]   skid_instr_p1, skid_instr_n;
  logic                 vld_skid_p1, vld_skid_n;
  logic                 ifid_vld_n;
  logic [ADDR_W-1:0]    ifid_pc_n;
  logic [INSTR_W-1:0]   ifid_instr_n;
  logic                 ifid_wr;
  logic [ADDR_W-1:0]    seq_pc;

  assign IMEM_REQ  = (state == S_FETCH);
  assign IMEM_ADDR = req_addr_p0;
  assign seq_pc    = req_addr_p0 + ADDR_W'(PC_INC);

  always_comb begin
    state_n      = state;
    pc_n         = pc_p0;
    drop_n       = drop;
    skid_pc_n    = skid_pc_p1;
    skid_instr_n = skid_instr_p1;
    vld_skid_n   = vld_skid_p1;
    ifid_vld_n   = IF_ID_VALID;
    ifid_pc_n    = IF_ID_PC;
    ifid_instr_n = IF_ID_INSTR;
    ifid_wr      = 1'b0;

    if (REDIRECT) begin
      pc_n         = REDIRECT_PC;
      ifid_vld_n   = 1'b0;
      ifid_instr_n = NOP_INSTR;
      vld_skid_n   = 1'b0;
      state_n      = S_FETCH;
      // An unacked request cannot be cancelled on the bus, so its response must be swallowed later.
      drop_n       = (state == S_FETCH) && !IMEM_ACK;
    end else begin
      case (state)
        S_IDLE: state_n = S_FETCH;
        S_FETCH: begin
          if (IMEM_ACK) begin
            if (drop) begin
              drop_n = 1'b0;
              if (IF_ID_VALID && ID_READY) ifid_vld_n = 1'b0;
            end else if (!IF_ID_VALID || ID_READY) begin
              ifid_vld_n   = 1'b1;
              ifid_pc_n    = req_addr_p0;
              ifid_instr_n = IMEM_RDATA;
              ifid_wr      = 1'b1;
              pc_n         = seq_pc;
            end else begin
              skid_pc_n    = req_addr_p0;
              skid_instr_n = IMEM_RDATA;
              vld_skid_n   = 1'b1;
              pc_n         = seq_pc;
              state_n      = S_FULL;
            end
          end else if (IF_ID_VALID && ID_READY) begin
            ifid_vld_n = 1'b0;
          end
        end
        S_FULL: begin
          if (ID_READY) begin
            ifid_vld_n   = vld_skid_p1;
            ifid_pc_n    = skid_pc_p1;
            ifid_instr_n = skid_instr_p1;
            ifid_wr      = vld_skid_p1;
            vld_skid_n   = 1'b0;
            state_n      = S_FETCH;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end

    // The address is frozen only while a request is still awaiting its ACK.
    req_addr_n = ((state == S_FETCH) && !IMEM_ACK) ? req_addr_p0 : pc_n;
  end

  // ---- state / control registers ----
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state       <= S_IDLE;
      pc_p0       <= RESET_PC;
      req_addr_p0 <= RESET_PC;
      drop        <= 1'b0;
      vld_skid_p1 <= 1'b0;
      IF_ID_VALID <= 1'b0;
      IF_ID_PC    <= '0;
      IF_ID_INSTR <= NOP_INSTR;
    end else begin
      state       <= state_n;
      pc_p0       <= pc_n;
      req_addr_p0 <= req_addr_n;
      drop        <= drop_n;
      vld_skid_p1 <= vld_skid_n;
      IF_ID_VALID <= ifid_vld_n;
      IF_ID_PC    <= ifid_pc_n;
      IF_ID_INSTR <= ifid_instr_n;
    end
  end

  // ---- skid data (qualified by vld_skid_p1) ----
  always_ff @(posedge CLK) begin
    skid_pc_p1    <= skid_pc_n;
    skid_instr_p1 <= skid_instr_n;
  end

`ifdef FETCH_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge CLK) begin
    if (!RST) begin
      PERF_FETCHED <= '0;
      PERF_STALL   <= '0;
    end else begin
      if (ifid_wr) PERF_FETCHED <= sat_inc(PERF_FETCHED);
      if (IF_ID_VALID && !ID_READY) PERF_STALL <= sat_inc(PERF_STALL);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a memory responder and an IF/ID scoreboard.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;

  int          checks   = 0;
  int          failures = 0;
  logic [63:0] sb[$];
  bit          stale    = 1'b0;
  int          wcnt     = 0;
  int          lat      = 0;
  bit          ack_en   = 1'b1;

  always #5 clk = ~clk;

  fetch_stage dut (
    .CLK         (clk),
    .RST         (rst),
    .IMEM_REQ    (imem_req),
    .IMEM_ADDR   (imem_addr),
    .IMEM_ACK    (imem_ack),
    .IMEM_RDATA  (imem_rdata),
    .REDIRECT    (redirect),
    .REDIRECT_PC (redirect_pc),
    .ID_READY    (id_ready),
    .IF_ID_VALID (if_id_valid),
    .IF_ID_PC    (if_id_pc),
    .IF_ID_INSTR (if_id_instr)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs just after an edge, update the model, advance to 1ns past the next edge.
  task automatic cyc(input bit rdy, input bit redir, input logic [31:0] rpc);
    logic        a;
    logic [63:0] e;
    a = rst && ack_en && (imem_req === 1'b1) && (wcnt >= lat);
    imem_ack    = a;
    imem_rdata  = a ? memf(imem_addr) : 32'h0;
    id_ready    = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    if (rst) begin
      if ((if_id_valid === 1'b1) && rdy) begin
        chk("sb_level", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("if_id_pc", if_id_pc, e[63:32]);
          chk("if_id_instr", if_id_instr, e[31:0]);
        end
      end
      if (redir) begin
        sb.delete();
        if (imem_req && !a) stale = 1'b1;
        else if (a) stale = 1'b0;
      end else if (a) begin
        if (stale) stale = 1'b0;
        else sb.push_back({imem_addr, memf(imem_addr)});
      end
      wcnt = (a || !imem_req) ? 0 : wcnt + 1;
    end else begin
      wcnt = 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; imem_ack = 1'b0; imem_rdata = '0; redirect = 1'b0;
    redirect_pc = '0; id_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset state
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 32'h0);
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_valid", if_id_valid, 0);
    chk("rst_pc", if_id_pc, 0);
    chk("rst_instr", if_id_instr, 32'h13);

    // 1: zero-wait memory, one instruction per cycle
    rst = 1'b1; lat = 0;
    cyc(1'b1, 1'b0, 32'h0);
    chk("t1_req_latency", imem_req, 1);
    for (int i = 0; i < 6; i++) begin
      chk("t1_addr", imem_addr, 32'(4 * i));
      cyc(1'b1, 1'b0, 32'h0);
      chk("t1_valid", if_id_valid, 1);
      chk("t1_ifid_pc", if_id_pc, 32'(4 * i));
    end

    // 2: three-cycle memory latency
    lat = 3;
    for (int j = 0; j < 4; j++) begin
      chk("t2_addr_hold", imem_addr, 32'd24);
      cyc(1'b1, 1'b0, 32'h0);
      if (j == 0) chk("t2_valid_gap", if_id_valid, 0);
    end
    chk("t2_valid", if_id_valid, 1);
    chk("t2_ifid_pc", if_id_pc, 32'd24);
    chk("t2_next_addr", imem_addr, 32'd28);
    lat = 0;

    // 3: ID stalls, skid fills and drains in order
    cyc(1'b0, 1'b0, 32'h0);
    chk("t3_full_req", imem_req, 0);
    for (int j = 0; j < 3; j++) begin
      cyc(1'b0, 1'b0, 32'h0);
      chk("t3_stall_req", imem_req, 0);
      chk("t3_stall_pc", if_id_pc, 32'd24);
      chk("t3_stall_valid", if_id_valid, 1);
    end
    cyc(1'b1, 1'b0, 32'h0);
    chk("t3_skid_pc", if_id_pc, 32'd28);
    chk("t3_refetch_req", imem_req, 1);
    chk("t3_refetch_addr", imem_addr, 32'd32);
    cyc(1'b1, 1'b0, 32'h0);
    chk("t3_after_pc", if_id_pc, 32'd32);

    // 4: redirect with a request outstanding
    lat = 2;
    cyc(1'b1, 1'b1, 32'h100);
    chk("t4_addr_held", imem_addr, 32'd36);
    chk("t4_valid", if_id_valid, 0);
    chk("t4_nop", if_id_instr, 32'h13);
    chk("t4_req", imem_req, 1);
    cyc(1'b1, 1'b0, 32'h0);
    chk("t4_addr_held2", imem_addr, 32'd36);
    cyc(1'b1, 1'b0, 32'h0);
    chk("t4_new_addr", imem_addr, 32'h100);
    chk("t4_dropped", if_id_valid, 0);
    lat = 0;
    cyc(1'b1, 1'b0, 32'h0);
    chk("t4_ifid_pc", if_id_pc, 32'h100);
    chk("t4_valid2", if_id_valid, 1);

    // 5a: redirect coincident with ACK
    cyc(1'b1, 1'b1, 32'h200);
    chk("t5a_valid", if_id_valid, 0);
    chk("t5a_nop", if_id_instr, 32'h13);
    chk("t5a_addr", imem_addr, 32'h200);
    cyc(1'b1, 1'b0, 32'h0);
    chk("t5a_ifid_pc", if_id_pc, 32'h200);

    // 5b: redirect while FULL
    cyc(1'b0, 1'b0, 32'h0);
    chk("t5b_full", imem_req, 0);
    cyc(1'b0, 1'b1, 32'h300);
    chk("t5b_valid", if_id_valid, 0);
    chk("t5b_nop", if_id_instr, 32'h13);
    chk("t5b_req", imem_req, 1);
    chk("t5b_addr", imem_addr, 32'h300);
    cyc(1'b1, 1'b0, 32'h0);
    chk("t5b_ifid_pc", if_id_pc, 32'h300);

    // 6: PC wrap-around, then reset mid-request
    cyc(1'b1, 1'b1, 32'hFFFF_FFFC);
    chk("t6_addr_top", imem_addr, 32'hFFFF_FFFC);
    cyc(1'b1, 1'b0, 32'h0);
    chk("t6_wrap_addr", imem_addr, 32'h0);
    chk("t6_top_pc", if_id_pc, 32'hFFFF_FFFC);
    cyc(1'b1, 1'b0, 32'h0);
    chk("t6_wrap_pc", if_id_pc, 32'h0);
    cyc(1'b1, 1'b0, 32'h0);
    chk("t6_pc4", if_id_pc, 32'h4);
    lat = 3;
    cyc(1'b1, 1'b0, 32'h0);
    chk("t6_pending_req", imem_req, 1);
    chk("t6_pending_addr", imem_addr, 32'h8);
    rst = 1'b0;
    cyc(1'b1, 1'b0, 32'h0);
    sb.delete(); stale = 1'b0; wcnt = 0;
    chk("t6_rst_req", imem_req, 0);
    chk("t6_rst_addr", imem_addr, 0);
    chk("t6_rst_valid", if_id_valid, 0);
    chk("t6_rst_pc", if_id_pc, 0);
    chk("t6_rst_instr", if_id_instr, 32'h13);
    rst = 1'b1; lat = 0;
    cyc(1'b1, 1'b0, 32'h0);
    chk("t6_restart_req", imem_req, 1);
    chk("t6_restart_addr", imem_addr, 0);
    cyc(1'b1, 1'b0, 32'h0);
    chk("t6_restart_pc", if_id_pc, 0);
    chk("t6_restart_valid", if_id_valid, 1);
    ack_en = 1'b0;
    cyc(1'b1, 1'b0, 32'h0);
    chk("drain_sb", 64'(sb.size()), 0);
    chk("drain_valid", if_id_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
